aes_block_pack: RTL and testbench

AES_BLOCK_PACK -- requirements
Module: aes_block_pack

---
 rtl/aes_block_pack.sv | 124 ++++++++++++
 tb/tb_aes_block_pack.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_pack.sv
// Packs a byte stream into 128-bit AES blocks (first byte in the MSB lane), zero-padding on early tlast.
// Optional idle-flush of partial blocks is enabled by defining AES_PACK_TIMEOUT_EN.
module aes_block_pack #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         s_axis_tlast,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [31:0]  blk_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_reg;
    logic [3:0]     idx_reg;
    logic [127:0]   pack_reg;
    logic [127:0]   pack_next;
    logic           s_tready_reg;
    logic           m_tvalid_reg;
    logic           m_tlast_reg;
    logic [31:0]    blk_cnt_reg;
    logic           in_beat;
    logic           out_beat;
    logic           blk_done;
    logic           timeout_fire;

    assign in_beat  = (state_reg == FILL) && s_tready_reg && s_axis_tvalid;
    assign out_beat = (state_reg == HOLD) && m_tvalid_reg && m_axis_tready;
    assign blk_done = in_beat && ((idx_reg == 4'd15) || s_axis_tlast);

    // Byte lane gi is written only when the incoming beat targets it; lane 0 is the MSB byte.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign pack_next[127 - 8*gi -: 8] = (in_beat && (idx_reg == 4'(gi)))
                                               ? s_axis_tdata
                                               : pack_reg[127 - 8*gi -: 8];
        end
    endgenerate

`ifdef AES_PACK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_reg;

    // Counts only while a partial block is waiting; any beat or leaving FILL restarts it.
    always_ff @(posedge clk) begin
        if (rst || (state_reg != FILL) || in_beat || (idx_reg == 4'd0)) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_reg + 1'b1;
        end
    end

    assign timeout_fire = (state_reg == FILL) && (idx_reg != 4'd0) && !in_beat
                          && (idle_reg == IDLE_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FILL;
            idx_reg      <= 4'd0;
            pack_reg     <= '0;
            s_tready_reg <= 1'b0;
            m_tvalid_reg <= 1'b0;
            m_tlast_reg  <= 1'b0;
            blk_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (blk_done || timeout_fire) begin
                        state_reg    <= HOLD;
                        pack_reg     <= pack_next;
                        s_tready_reg <= 1'b0;
                        m_tvalid_reg <= 1'b1;
                        m_tlast_reg  <= blk_done ? s_axis_tlast : 1'b1;
                    end else begin
                        s_tready_reg <= 1'b1;
                        if (in_beat) begin
                            pack_reg <= pack_next;
                            idx_reg  <= idx_reg + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_beat) begin
                        state_reg    <= FILL;
                        idx_reg      <= 4'd0;
                        pack_reg     <= '0;
                        s_tready_reg <= 1'b1;
                        m_tvalid_reg <= 1'b0;
                        m_tlast_reg  <= 1'b0;
                        blk_cnt_reg  <= blk_cnt_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase
        end
    end

    // The pack register doubles as the output word: it is zero outside a block and frozen in HOLD.
    assign m_axis_tdata  = pack_reg;
    assign m_axis_tvalid = m_tvalid_reg;
    assign m_axis_tlast  = m_tlast_reg;
    assign s_axis_tready = s_tready_reg;
    assign blk_cnt       = blk_cnt_reg;

endmodule

// File: tb/tb_aes_block_pack.sv
// Scoreboard bench for aes_block_pack: byte beats feed a packing model, output blocks are popped and compared.
module tb_aes_block_pack;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   s_tdata = 8'd0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic         m_tlast;
    logic [31:0]  blk_cnt;

    always #5 clk = ~clk;

    aes_block_pack #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .blk_cnt       (blk_cnt)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } blk_t;

    int           checks = 0;
    int           errors = 0;
    blk_t         exp_q[$];
    blk_t         mon_e;
    logic [127:0] mdl_word = '0;
    int           mdl_idx = 0;
    int           rx_count = 0;
    bit           rand_rdy = 1'b0;

    // Output-side scoreboard: a transfer is seen at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (!rst && m_tvalid) begin
            checks++;
            if (s_tready !== 1'b0) begin
                errors++;
                $display("FAIL tready_in_hold s_tready=%b required=0", s_tready);
            end
        end
        if (!rst && m_tvalid && m_tready) begin
            checks++;
            rx_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_block got=%h last=%b", m_tdata, m_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_tdata !== mon_e.data || m_tlast !== mon_e.last) begin
                    errors++;
                    $display("FAIL block_data got=%h/%b required=%h/%b",
                             m_tdata, m_tlast, mon_e.data, mon_e.last);
                end else begin
                    $display("block %0d data=%h last=%b", rx_count, m_tdata, m_tlast);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic last);
        mdl_word[127 - 8*mdl_idx -: 8] = b;
        mdl_idx++;
        if (mdl_idx == 16 || last) begin
            exp_q.push_back({mdl_word, last});
            mdl_word = '0;
            mdl_idx  = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, output int cycles);
        bit done;
        done     = 1'b0;
        cycles   = 0;
        s_tdata  = b;
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!done && cycles < 200) begin
            @(negedge clk);
            if (s_tready) begin
                model_byte(b, last);
                done = 1'b1;
            end
            tick();
            cycles++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout byte=%h accepted=0 required=1", b);
        end
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rst      = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        exp_q.delete();
        mdl_word = '0;
        mdl_idx  = 0;
        rx_count = 0;
        tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_s_tready", 128'(s_tready), 128'd0);
        chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_m_tlast", 128'(m_tlast), 128'd0);
        chk("rst_m_tdata", m_tdata, 128'd0);
        chk("rst_blk_cnt", 128'(blk_cnt), 128'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_tready", 128'(s_tready), 128'd1);
    endtask

    task automatic test_count();
        int c;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, c);
        chk("count_tvalid_latency", 128'(m_tvalid), 128'd1);
        chk("count_tdata", m_tdata, 128'h000102030405060708090A0B0C0D0E0F);
        chk("count_tlast", 128'(m_tlast), 128'd0);
        wait_drain();
        chk("count_blk_cnt", 128'(blk_cnt), 128'd1);
        chk("count_refill_tready", 128'(s_tready), 128'd1);
    endtask

    task automatic test_back_to_back();
        int c;
        int total;
        do_reset();
        m_tready = 1'b1;
        total = 0;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(8'h40 + i), 1'b0, c);
            total += c;
        end
        chk("b2b_cycles", 128'(total), 128'd33);
        wait_drain();
        chk("b2b_blk_cnt", 128'(blk_cnt), 128'd2);
    endtask

    task automatic test_partial();
        int c;
        do_reset();
        m_tready = 1'b1;
        send_byte(8'hAA, 1'b0, c);
        send_byte(8'hBB, 1'b0, c);
        send_byte(8'hCC, 1'b1, c);
        chk("partial_tvalid", 128'(m_tvalid), 128'd1);
        chk("partial_tdata", m_tdata, 128'hAABBCC00000000000000000000000000);
        chk("partial_tlast", 128'(m_tlast), 128'd1);
        wait_drain();
        chk("partial_blk_cnt", 128'(blk_cnt), 128'd1);
    endtask

    task automatic test_hold();
        int c;
        logic [127:0] w;
        do_reset();
        m_tready = 1'b0;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h80 + i), 1'b0, c);
            w = {w[119:0], 8'(8'h80 + i)};
        end
        for (int k = 0; k < 5; k++) begin
            chk("hold_tvalid", 128'(m_tvalid), 128'd1);
            chk("hold_tdata", m_tdata, w);
            chk("hold_s_tready", 128'(s_tready), 128'd0);
            tick();
        end
        m_tready = 1'b1;
        wait_drain();
        chk("hold_rx_once", 128'(rx_count), 128'd1);
        chk("hold_blk_cnt", 128'(blk_cnt), 128'd1);
        chk("hold_resume", 128'({m_tvalid, s_tready}), 128'b01);
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        m_tready = 1'b1;
        for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b0, c);
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0, c);
        chk("rstmid_tdata", m_tdata, 128'h101112131415161718191A1B1C1D1E1F);
        wait_drain();
        chk("rstmid_blk_cnt", 128'(blk_cnt), 128'd1);
        chk("rstmid_rx_count", 128'(rx_count), 128'd1);
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'hE0 + i), 1'b0, c);
        chk("rsthold_pending", 128'(m_tvalid), 128'd1);
        do_reset();
        m_tready = 1'b1;
        repeat (5) tick();
        chk("rsthold_tvalid", 128'(m_tvalid), 128'd0);
        chk("rsthold_blk_cnt", 128'(blk_cnt), 128'd0);
        chk("rsthold_rx_count", 128'(rx_count), 128'd0);
    endtask

    task automatic test_timeout();
        int c;
        do_reset();
        m_tready = 1'b1;
        send_byte(8'h55, 1'b0, c);
        send_byte(8'h66, 1'b0, c);
`ifdef AES_PACK_TIMEOUT_EN
        repeat (TO - 1) tick();
        chk("timeout_early", 128'(m_tvalid), 128'd0);
        tick();
        chk("timeout_tvalid", 128'(m_tvalid), 128'd1);
        chk("timeout_tdata", m_tdata, 128'h55660000000000000000000000000000);
        chk("timeout_tlast", 128'(m_tlast), 128'd1);
        exp_q.push_back({mdl_word, 1'b1});
        mdl_word = '0;
        mdl_idx  = 0;
        wait_drain();
        chk("timeout_blk_cnt", 128'(blk_cnt), 128'd1);
`else
        repeat (40) tick();
        chk("no_timeout_tvalid", 128'(m_tvalid), 128'd0);
        chk("no_timeout_tready", 128'(s_tready), 128'd1);
        chk("no_timeout_blk_cnt", 128'(blk_cnt), 128'd0);
`endif
        do_reset();
    endtask

    task automatic test_random();
        int c;
        int gap;
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            gap = 0;
            while ($urandom_range(0, 2) == 0 && gap < 3) begin
                tick();
                gap++;
            end
            send_byte(8'($urandom_range(0, 255)), 1'b0, c);
        end
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        wait_drain();
        repeat (2) tick();
        chk("rand_blk_cnt", 128'(blk_cnt), 128'd62);
        chk("rand_rx_count", 128'(rx_count), 128'd62);
        chk("rand_pending_bytes", 128'(mdl_idx), 128'd8);
        chk("rand_pending_hold", 128'({m_tvalid, s_tready}), 128'b01);
    endtask

    initial begin
        test_reset();
        test_count();
        test_back_to_back();
        test_partial();
        test_hold();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
